// File: rtl/rangefinder_sopc_apd_overcurrent_poller.sv
// APD overcurrent poller: an Avalon-MM master that periodically reads the
// overcurrent PIO (address 0, read latency 1), debounces readdata[0] and
// raises a sticky trip flag for the bias-shutdown logic.
module rangefinder_sopc_apd_overcurrent_poller #(
    parameter int unsigned POLL_PERIOD = 1000,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_clear_trip,
    output logic [1:0]  o_address,
    output logic        o_read,
    input  logic        i_waitrequest,
    input  logic [31:0] i_readdata,
    output logic        o_trip,
    output logic        o_sample_valid,
    output logic        o_sample_bit,
    output logic [15:0] o_poll_count
);

    localparam int unsigned CntWidth = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(POLL_PERIOD - 1);
    localparam logic [7:0] HitMax = 8'(DEBOUNCE);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StCapture
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_next;
    logic [7:0]          r_hit_cnt;
    logic [7:0]          w_hit_next;
    logic                w_trip_set;
    logic                r_trip;
    logic                r_sample_bit;
    logic [15:0]         r_poll_count;

    // Only bit 0 of the PIO data carries the overcurrent status.
    logic w_unused_readdata;
    assign w_unused_readdata = ^i_readdata[31:1];

    // Next-state, period counter and debounce update.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hit_next   = r_hit_cnt;
        w_trip_set   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!i_enable) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CntLast) begin
                    w_cnt_next   = '0;
                    w_state_next = StReq;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StReq: begin
                // Read stays asserted until the slave stops stalling.
                if (!i_waitrequest) begin
                    w_state_next = StCapture;
                end
            end
            StCapture: begin
                // Readdata is valid here because the slave has read latency 1.
                if (i_readdata[0]) begin
                    w_hit_next = (r_hit_cnt == HitMax) ? r_hit_cnt : r_hit_cnt + 8'd1;
                end else begin
                    w_hit_next = 8'd0;
                end
                w_trip_set   = (w_hit_next == HitMax);
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State, counters, captured sample and sticky trip.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_hit_cnt    <= 8'd0;
            r_trip       <= 1'b0;
            r_sample_bit <= 1'b0;
            r_poll_count <= 16'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_hit_cnt <= w_hit_next;
            if (r_state == StCapture) begin
                r_sample_bit <= i_readdata[0];
                r_poll_count <= r_poll_count + 16'd1;
            end
            // A new trip event takes priority over a simultaneous clear.
            if (w_trip_set) begin
                r_trip <= 1'b1;
            end else if (i_clear_trip) begin
                r_trip <= 1'b0;
            end
        end
    end

    assign o_address      = 2'b00;
    assign o_read         = (r_state == StReq);
    assign o_sample_valid = (r_state == StCapture);
    assign o_sample_bit   = r_sample_bit;
    assign o_trip         = r_trip;
    assign o_poll_count   = r_poll_count;

endmodule

// File: tb/tb_rangefinder_sopc_apd_overcurrent_poller.sv
// Randomized self-checking bench for the APD overcurrent poller, compared
// cycle by cycle against a transaction-level reference model.
module tb_rangefinder_sopc_apd_overcurrent_poller;

    localparam int unsigned P = 4;
    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] rd = 32'd0;
    logic [1:0]  address;
    logic        read;
    logic        trip;
    logic        sv;
    logic        sbit;
    logic [15:0] pc;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: "waited" counts enabled idle cycles since the last
    // transaction; a request opens once P of them have elapsed.
    int waited;
    bit req_open;
    int req_age;
    bit cap_now;
    int hits;
    bit m_trip;
    bit m_sbit;
    int polls;

    rangefinder_sopc_apd_overcurrent_poller #(
        .POLL_PERIOD(P),
        .DEBOUNCE   (D)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_enable      (en),
        .i_clear_trip  (clr),
        .o_address     (address),
        .o_read        (read),
        .i_waitrequest (wr),
        .i_readdata    (rd),
        .o_trip        (trip),
        .o_sample_valid(sv),
        .o_sample_bit  (sbit),
        .o_poll_count  (pc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        waited   = 0;
        req_open = 1'b0;
        req_age  = 0;
        cap_now  = 1'b0;
        hits     = 0;
        m_trip   = 1'b0;
        m_sbit   = 1'b0;
        polls    = 0;
    endtask

    // Called at posedge+1 with inputs driven; checks mid-cycle, advances model.
    task automatic step();
        bit set;
        #4;
        check_val("address", 32'(address), 32'd0);
        check_val("read", 32'(read), 32'(req_open));
        check_val("sample_valid", 32'(sv), 32'(cap_now));
        check_val("sample_bit", 32'(sbit), 32'(m_sbit));
        check_val("trip", 32'(trip), 32'(m_trip));
        check_val("poll_count", 32'(pc), 32'(polls % 65536));
        set = 1'b0;
        if (cap_now) begin
            m_sbit  = rd[0];
            polls   = (polls + 1) % 65536;
            hits    = rd[0] ? ((hits + 1 > int'(D)) ? int'(D) : hits + 1) : 0;
            set     = (hits == int'(D));
            cap_now = 1'b0;
        end else if (req_open) begin
            if (!wr) begin
                req_open = 1'b0;
                cap_now  = 1'b1;
            end else begin
                req_age++;
            end
        end else if (!en) begin
            waited = 0;
        end else if (waited + 1 == int'(P)) begin
            waited   = 0;
            req_open = 1'b1;
            req_age  = 0;
        end else begin
            waited++;
        end
        if (set) m_trip = 1'b1;
        else if (clr) m_trip = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pat[7];
        int k;
        bit was_cap;
        int budget;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        model_reset();

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_read", 32'(read), 32'd0);
        check_val("rst_trip", 32'(trip), 32'd0);
        check_val("rst_sv", 32'(sv), 32'd0);
        check_val("rst_pc", 32'(pc), 32'd0);
        reset_n = 1'b1;

        // Basic cadence, data 0, no stall.
        en = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Debounce pattern 1,1,0,1,1,1,1: trip only after the 7th capture.
        k = 0;
        budget = 0;
        while (k < 7 && budget < 100) begin
            rd = $urandom();
            rd[0] = pat[k];
            was_cap = cap_now;
            step();
            budget++;
            if (was_cap) begin
                k++;
                if (k == 6) check_val("trip_early", 32'(trip), 32'd0);
                if (k == 7) check_val("trip_after7", 32'(trip), 32'd1);
            end
        end
        check_val("debounce_done", 32'(k), 32'd7);

        // Stall each request for 5 cycles.
        for (int i = 0; i < 30; i++) begin
            rd = $urandom();
            wr = req_open && (req_age < 5);
            step();
        end
        wr = 1'b0;

        // Overcurrent persists; clears pulsed randomly and on capture cycles.
        for (int i = 0; i < 40; i++) begin
            rd = $urandom();
            rd[0] = 1'b1;
            clr = cap_now ? 1'b1 : ($urandom_range(0, 3) == 0);
            step();
        end
        clr = 1'b0;

        // Drop enable as read asserts, with a 3-cycle stall.
        budget = 0;
        while (!req_open && budget < 20) begin
            step();
            budget++;
        end
        check_val("req_reached", 32'(req_open), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            wr = req_open && (req_age < 3);
            rd = $urandom();
            step();
        end
        wr = 1'b0;

        // Fully random traffic.
        for (int i = 0; i < 300; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            wr  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 5) == 0);
            rd  = $urandom();
            step();
        end

        // Asynchronous reset while a stalled request is outstanding.
        en = 1'b1;
        wr = 1'b1;
        clr = 1'b0;
        rd = 32'd1;
        budget = 0;
        while (!req_open && budget < 20) begin
            step();
            budget++;
        end
        check_val("req_before_rst", 32'(read), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("arst_read", 32'(read), 32'd0);
        check_val("arst_trip", 32'(trip), 32'd0);
        check_val("arst_pc", 32'(pc), 32'd0);
        check_val("arst_sv", 32'(sv), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rd = $urandom();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rangefinder_sopc_apd_overcurrent_poller.md
Name: rangefinder_sopc_apd_overcurrent_poller

Overview:
- Avalon-MM master that periodically reads the APD overcurrent PIO slave (1-bit input port, address 0, registered readdata) and debounces bit 0.
- Raises a sticky trip flag for the bias-shutdown logic.
- Sits in the rangefinder SOPC fabric, on the initiator side of the overcurrent PIO's s1 port.

Parameters:
- POLL_PERIOD, 1000, idle cycles between the end of one read and the next read request; legal range is at least 1.
- DEBOUNCE, 4, consecutive samples of 1 required to trip; legal range is 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  polling enable
- clear_trip  in  1  single-cycle pulse; clears trip
- address  out  2  master address; constant 0
- read  out  1  Avalon read request
- waitrequest  in  1  slave stall
- readdata  in  32  slave read data; only bit 0 is used
- trip  out  1  sticky overcurrent flag
- sample_valid  out  1  one-cycle pulse when a new sample is captured
- sample_bit  out  1  last captured readdata[0]
- poll_count  out  16  number of completed reads; wraps

Behaviour:
- One clock. Reset is asynchronous and active-low. All state is in the clk/reset_n domain.
- Reset values:
  - State is IDLE.
  - Period counter, hit_cnt and poll_count are 0.
  - read, trip, sample_valid and sample_bit are 0.
  - address is always 2'b00.
- State machine:
  - IDLE:
    - If enable=0, the period counter holds at 0.
    - If enable=1, the counter increments each cycle.
    - When counter==POLL_PERIOD-1, the counter goes to 0 and the next state is REQ.
  - REQ:
    - read=1 and address=0.
    - If waitrequest=1, stay in REQ with read held high. Never drop read while stalled.
    - If waitrequest=0 at the edge, the transfer is accepted and the next state is CAPTURE.
  - CAPTURE:
    - The slave has fixed read latency 1, so readdata is valid in this cycle.
    - Register readdata[0] into sample_bit.
    - Pulse sample_valid for exactly this cycle.
    - poll_count increments, wrapping from 16'hFFFF to 0.
    - Update hit_cnt, then return to IDLE.
- Read cadence with waitrequest=0: one read every POLL_PERIOD+2 cycles.
- enable deasserted while in REQ or CAPTURE: the transaction completes normally, then the block parks in IDLE. hit_cnt and trip are retained.
- Debounce:
  - On each capture: if bit=1, hit_cnt = min(hit_cnt+1, DEBOUNCE); if bit=0, hit_cnt = 0.
  - hit_cnt width is 8 bits.
- Trip:
  - trip sets in the cycle after a capture whose updated hit_cnt equals DEBOUNCE.
  - trip stays set until clear_trip.
  - clear_trip does not modify hit_cnt. If overcurrent persists, trip re-sets on the next capture.
  - clear_trip and a set event in the same cycle: set wins.
  - clear_trip with trip=0 has no effect.
- Reset mid-transaction: read drops immediately (asynchronous) and all state returns to reset values. The slave tolerates an abandoned read.

Test Plan:
- Reset, then enable=1 with POLL_PERIOD=4, waitrequest=0, readdata=0 -> read high for 1 cycle every 6 cycles; sample_valid 1 cycle after each read; poll_count 1,2,3; trip=0.
- DEBOUNCE=4, readdata[0] sequence 1,1,0,1,1,1,1 -> hit_cnt 1,2,0,1,2,3,4; trip rises the cycle after the 7th sample_valid, not earlier.
- waitrequest held high for 5 cycles during REQ -> read stays 1 with address=0 for all 6 cycles; capture occurs the cycle after waitrequest falls; no duplicate sample_valid.
- trip=1 with readdata[0] still 1, pulse clear_trip -> trip=0 next cycle, re-asserts after next capture. clear_trip in the same cycle as a set event -> trip stays 1.
- enable dropped the cycle read is asserted with waitrequest=1 for 3 cycles -> read completes, one sample_valid, then no further reads; trip/hit_cnt unchanged.
- Assert reset_n=0 while in REQ -> read, trip and poll_count are 0 asynchronously. After release with enable=1, the first read comes after POLL_PERIOD cycles.
